round_pipe_unit: RTL and testbench

- Parametrised, pipelined significand rounding stage for the floating-point add/sub datapath. It replaces the fixed 2-LSB rounding phase.
- Takes the normalised significand plus W_GRS extra low-order bits. It applies one of four IEEE-754 rounding modes, including round-to-nearest-even, and returns the rounded significand with carry-out and inexact flags.
- Uses a 2-stage valid/ready pipeline so the datapath can stall without losing operands.

---
 rtl/round_pipe_unit_pkg.sv | 16 +
 rtl/round_pipe_unit_if.sv | 30 +++
 rtl/round_pipe_unit_round_decision.sv | 29 ++
 rtl/round_pipe_unit.sv | 96 +++++++++
 tb/tb_round_pipe_unit.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/round_pipe_unit_pkg.sv
// Shared constants for the FP add/sub significand rounding stage.
package fp_round_pkg;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  // Stored significand widths; the kept field is one bit wider (hidden one).
  localparam int W_SGF_SINGLE = 23;
  localparam int W_SGF_DOUBLE = 52;

  localparam int W_GRS_MIN = 2;
  localparam int W_GRS_MAX = 8;

endpackage

// File: rtl/round_pipe_unit_if.sv
// Operand/result bus of the rounding pipe: one valid/ready channel in, one out.
interface round_pipe_unit_if #(
   parameter int W_Sgf = 23,
   parameter int W_GRS = 2
);
   // A beat transfers on a rising edge where valid & ready are both 1; the
   // producer holds valid and payload stable until then, ready may depend on
   // the consumer's own ready combinationally but never on valid.
   logic                   in_valid;
   logic                   in_ready;
   logic [W_Sgf+W_GRS:0]   Sgf_N;
   logic [1:0]             r_mode;
   logic                   Sgn_M;
   logic                   out_valid;
   logic                   out_ready;
   logic [W_Sgf+1:0]       Sgf_Ready;
   logic                   Ovf;
   logic                   Inexact;

   modport master (
      output in_valid, Sgf_N, r_mode, Sgn_M, out_ready,
      input  in_ready, out_valid, Sgf_Ready, Ovf, Inexact
   );

   modport slave (
      input  in_valid, Sgf_N, r_mode, Sgn_M, out_ready,
      output in_ready, out_valid, Sgf_Ready, Ovf, Inexact
   );

endinterface

// File: rtl/round_pipe_unit_round_decision.sv
// Rounding decoder: decides whether the kept field is incremented.
module round_decision
   import fp_round_pkg::*;
(
   input  logic       i_l,
   input  logic       i_g,
   input  logic       i_s,
   input  logic       i_sgn,
   input  logic [1:0] i_mode,
   output logic       o_inc,
   output logic       o_inexact
);

   logic w_x;
   assign w_x       = i_g | i_s;
   assign o_inexact = w_x;

   always_comb begin
      o_inc = 1'b0;
      case (i_mode)
         RM_RNE:  o_inc = i_g & (i_s | i_l);
         RM_RTZ:  o_inc = 1'b0;
         RM_RUP:  o_inc = w_x & ~i_sgn;
         RM_RDN:  o_inc = w_x & i_sgn;
         default: o_inc = 1'b0;
      endcase
   end

endmodule

// File: rtl/round_pipe_unit.sv
// Two-stage valid/ready significand rounding pipe: decide in stage 1,
// add the increment in stage 2 so the carry chain gets its own cycle.
module round_pipe_unit
   import fp_round_pkg::*;
#(
   parameter int W_Sgf = 23,
   parameter int W_GRS = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   round_pipe_unit_if.slave  bus
);

   logic [W_Sgf:0]   w_kept;
   logic             w_l;
   logic             w_g;
   logic             w_s;
   logic             w_inc;
   logic             w_x;
   logic             w_s2_load;
   logic             w_in_ready;
   logic             w_in_fire;
   logic [W_Sgf+1:0] w_sum;

   logic             r_s1_valid;
   logic [W_Sgf:0]   r_s1_kept;
   logic             r_s1_inc;
   logic             r_s1_x;
   logic             r_s2_valid;
   logic [W_Sgf+1:0] r_s2_sgf;
   logic             r_s2_inexact;

   assign w_kept = bus.Sgf_N[W_Sgf+W_GRS:W_GRS];
   assign w_l    = bus.Sgf_N[W_GRS];
   assign w_g    = bus.Sgf_N[W_GRS-1];
   assign w_s    = |bus.Sgf_N[W_GRS-2:0];

   round_decision u_dec (
      .i_l       (w_l),
      .i_g       (w_g),
      .i_s       (w_s),
      .i_sgn     (bus.Sgn_M),
      .i_mode    (bus.r_mode),
      .o_inc     (w_inc),
      .o_inexact (w_x)
   );

   // Ready looks through to out_ready so a full pipe still streams at 1/cycle.
   assign w_s2_load  = ~r_s2_valid | bus.out_ready;
   assign w_in_ready = ~r_s1_valid | w_s2_load;
   assign w_in_fire  = bus.in_valid & w_in_ready & ~flush;
   assign w_sum      = {1'b0, r_s1_kept} + {{(W_Sgf+1){1'b0}}, r_s1_inc};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_kept  <= '0;
         r_s1_inc   <= 1'b0;
         r_s1_x     <= 1'b0;
      end else if (flush) begin
         r_s1_valid <= 1'b0;
      end else if (w_in_fire) begin
         r_s1_valid <= 1'b1;
         r_s1_kept  <= w_kept;
         r_s1_inc   <= w_inc;
         r_s1_x     <= w_x;
      end else if (w_s2_load) begin
         r_s1_valid <= 1'b0;
      end
   end

   // Data only moves with a valid operand, so a stalled result never changes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_valid   <= 1'b0;
         r_s2_sgf     <= '0;
         r_s2_inexact <= 1'b0;
      end else if (flush) begin
         r_s2_valid <= 1'b0;
      end else if (w_s2_load) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_sgf     <= w_sum;
            r_s2_inexact <= r_s1_x;
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_s2_valid;
   assign bus.Sgf_Ready = r_s2_sgf;
   assign bus.Ovf       = r_s2_sgf[W_Sgf+1];
   assign bus.Inexact   = r_s2_inexact;

endmodule

// File: tb/tb_round_pipe_unit.sv
// Directed bench for round_pipe_unit (single precision, two extra bits).
module tb_round_pipe_unit;
   import fp_round_pkg::*;

   localparam int W_SGF = 23;
   localparam int W_GRS = 2;
   localparam int W_OUT = W_SGF + 2;

   logic clk = 1'b0;
   logic rst;
   logic flush;

   round_pipe_unit_if #(.W_Sgf(W_SGF), .W_GRS(W_GRS)) bus ();

   round_pipe_unit #(.W_Sgf(W_SGF), .W_GRS(W_GRS)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   logic [W_OUT:0] exp_q[$];   // {inexact, sgf_ready}

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard: every consumed result must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && !flush && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            check_val("spurious_out", 32'(bus.out_valid), 32'd0);
         end else begin
            logic [W_OUT:0] e;
            e = exp_q.pop_front();
            check_val("sgf_ready", 32'(bus.Sgf_Ready), 32'(e[W_OUT-1:0]));
            check_val("ovf", 32'(bus.Ovf), 32'(e[W_OUT-1]));
            check_val("inexact", 32'(bus.Inexact), 32'(e[W_OUT]));
         end
      end
   end

   task automatic drive(input logic [W_SGF:0] kept, input logic [1:0] ext,
                        input logic [1:0] mode, input logic sgn);
      bus.Sgf_N  = {kept, ext};
      bus.r_mode = mode;
      bus.Sgn_M  = sgn;
   endtask

   task automatic send(input logic [W_SGF:0] kept, input logic [1:0] ext,
                       input logic [1:0] mode, input logic sgn,
                       input logic [W_OUT-1:0] exp_sgf, input logic exp_inx);
      int n = 0;
      drive(kept, ext, mode, sgn);
      bus.in_valid = 1'b1;
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_val("send_accept", 32'(bus.in_ready), 32'd1);
      exp_q.push_back({exp_inx, exp_sgf});
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 30) begin
         @(posedge clk);
         n++;
      end
      #1;
      check_val("drain", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int acc;
      logic [W_SGF:0] bp_kept[4];
      logic [1:0]     bp_ext[4];
      logic [1:0]     bp_mode[4];

      rst = 1'b1;
      flush = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      drive('0, 2'b00, RM_RNE, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check_val("rst_sgf", 32'(bus.Sgf_Ready), 32'd0);
      check_val("rst_ovf", 32'(bus.Ovf), 32'd0);
      check_val("rst_inexact", 32'(bus.Inexact), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);

      // Latency: out_valid low one edge after transfer, high after the second.
      drive(24'hFFFFFF, 2'b11, RM_RNE, 1'b0);
      bus.in_valid = 1'b1;
      exp_q.push_back({1'b1, 25'h1000000});
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check_val("lat_edge1", 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      #1;
      check_val("lat_edge2", 32'(bus.out_valid), 32'd1);
      drain();

      // Round to nearest even, ties and carry
      send(24'h800001, 2'b10, RM_RNE, 1'b0, 25'h0800002, 1'b1);
      send(24'h800000, 2'b10, RM_RNE, 1'b0, 25'h0800000, 1'b1);
      send(24'h800000, 2'b11, RM_RNE, 1'b1, 25'h0800001, 1'b1);
      send(24'hFFFFFF, 2'b10, RM_RNE, 1'b0, 25'h1000000, 1'b1);
      // Directed modes, G=0 S=1
      send(24'h8000F0, 2'b01, RM_RUP, 1'b0, 25'h08000F1, 1'b1);
      send(24'h8000F0, 2'b01, RM_RUP, 1'b1, 25'h08000F0, 1'b1);
      send(24'h8000F0, 2'b01, RM_RDN, 1'b1, 25'h08000F1, 1'b1);
      send(24'h8000F0, 2'b01, RM_RDN, 1'b0, 25'h08000F0, 1'b1);
      send(24'h8000F0, 2'b01, RM_RTZ, 1'b0, 25'h08000F0, 1'b1);
      send(24'h8000F0, 2'b01, RM_RNE, 1'b0, 25'h08000F0, 1'b1);
      send(24'hFFFFFF, 2'b11, RM_RUP, 1'b0, 25'h1000000, 1'b1);
      // Exact inputs never round
      send(24'hFFFFFF, 2'b00, RM_RNE, 1'b0, 25'h0FFFFFF, 1'b0);
      send(24'hFFFFFF, 2'b00, RM_RTZ, 1'b1, 25'h0FFFFFF, 1'b0);
      send(24'hFFFFFF, 2'b00, RM_RUP, 1'b0, 25'h0FFFFFF, 1'b0);
      send(24'hFFFFFF, 2'b00, RM_RDN, 1'b1, 25'h0FFFFFF, 1'b0);
      drain();

      // Backpressure: four operands offered with the consumer stalled
      bp_kept = '{24'h123456, 24'h123457, 24'h0000FF, 24'h7FFFFF};
      bp_ext  = '{2'b10, 2'b10, 2'b11, 2'b01};
      bp_mode = '{RM_RNE, RM_RNE, RM_RTZ, RM_RUP};
      bus.out_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 6; c++) begin
         drive(bp_kept[acc], bp_ext[acc], bp_mode[acc], 1'b0);
         bus.in_valid = 1'b1;
         @(negedge clk);
         if (bus.in_ready) begin
            @(posedge clk);
            acc++;
         end else begin
            @(posedge clk);
         end
         #1;
      end
      check_val("bp_accepted", 32'(acc), 32'd2);
      check_val("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check_val("bp_out_valid", 32'(bus.out_valid), 32'd1);
      for (int c = 0; c < 3; c++) begin
         check_val("bp_hold_sgf", 32'(bus.Sgf_Ready), 32'h0123456);
         check_val("bp_hold_inx", 32'(bus.Inexact), 32'd1);
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      exp_q.push_back({1'b1, 25'h0123456});
      exp_q.push_back({1'b1, 25'h0123458});
      bus.out_ready = 1'b1;
      send(bp_kept[2], bp_ext[2], bp_mode[2], 1'b0, 25'h00000FF, 1'b1);
      send(bp_kept[3], bp_ext[3], bp_mode[3], 1'b0, 25'h0800000, 1'b1);
      drain();

      // Reset with both stages full
      bus.out_ready = 1'b0;
      drive(24'h0ABCDE, 2'b11, RM_RNE, 1'b0);
      bus.in_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check_val("pre_rst_full", 32'(bus.out_valid), 32'd1);
      #3;
      rst = 1'b1;
      #1;
      check_val("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
      check_val("mid_rst_sgf", 32'(bus.Sgf_Ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         #1;
         check_val("post_rst_no_stale", 32'(bus.out_valid), 32'd0);
      end

      // Flush with one operand in flight and another offered concurrently
      drive(24'h111111, 2'b10, RM_RNE, 1'b0);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      drive(24'h222222, 2'b11, RM_RNE, 1'b0);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      bus.in_valid = 1'b0;
      check_val("flush_out_valid", 32'(bus.out_valid), 32'd0);
      check_val("flush_in_ready", 32'(bus.in_ready), 32'd1);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         check_val("post_flush_empty", 32'(bus.out_valid), 32'd0);
      end

      // Pipe still usable afterwards
      send(24'h333333, 2'b10, RM_RNE, 1'b0, 25'h0333334, 1'b1);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
